// File: rtl/onehot_encoder_seq_if.sv
// onehot_encoder_seq_if: request/index handshake bundle between producer, encoder and consumer
interface onehot_encoder_seq_if #(parameter int WIDTH = 16);
  localparam int IDX_W = $clog2(WIDTH);
  logic [WIDTH-1:0] req_vec;
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] idx;
  logic             idx_valid;
  logic             idx_ready;
  logic             idx_last;
  logic [IDX_W:0]   count;
  logic             zero_req;
  logic             flush;
  modport master (output req_vec, req_valid, idx_ready, flush,
                  input  req_ready, idx, idx_valid, idx_last, count, zero_req);
  modport slave  (input  req_vec, req_valid, idx_ready, flush,
                  output req_ready, idx, idx_valid, idx_last, count, zero_req);
endinterface

// File: rtl/onehot_encoder_seq.sv
// onehot_encoder_seq: streams the index of every set bit of a captured vector, one per handshake
module onehot_encoder_seq #(
  parameter int WIDTH     = 16,
  parameter int LSB_FIRST = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  onehot_encoder_seq_if.slave  bus
);
  localparam int IDX_W = $clog2(WIDTH);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [IDX_W:0]   count_q, count_d;
  logic             zero_q, zero_d;
  logic [IDX_W-1:0] idx_c;
  logic             single;
  function automatic logic [IDX_W:0] popcnt(input logic [WIDTH-1:0] v);
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) popcnt += {{IDX_W{1'b0}}, v[i]};
  endfunction
  // Scan away from the preferred end so the last hit is the winner
  always_comb begin
    idx_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      int j;
      j = LSB_FIRST != 0 ? WIDTH - 1 - i : i;
      if (pending_q[j]) idx_c = IDX_W'(j);
    end
  end
  assign single = pending_q != '0 && (pending_q & (pending_q - WIDTH'(1))) == '0;
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    zero_d    = 1'b0;
    if (bus.flush) begin
      state_d   = IDLE;
      pending_d = '0;
    end else if (state_q == IDLE && bus.req_valid) begin
      pending_d = bus.req_vec;
      count_d   = popcnt(bus.req_vec);
      state_d   = bus.req_vec != '0 ? BUSY : IDLE;
      zero_d    = bus.req_vec == '0;
    end else if (state_q == BUSY && bus.idx_ready) begin
      pending_d[idx_c] = 1'b0;
      state_d          = single ? IDLE : BUSY;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      count_q   <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      zero_q    <= zero_d;
    end
  assign bus.req_ready = state_q == IDLE;
  assign bus.idx_valid = state_q == BUSY;
  assign bus.idx       = idx_c;
  assign bus.idx_last  = state_q == BUSY && single;
  assign bus.count     = count_q;
  assign bus.zero_req  = zero_q;
endmodule
